// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver with 16x oversampling and 3-sample majority voting,
//   feeding a first-word-fall-through byte FIFO with a valid/ready output.
//   Framing and overrun errors are held in sticky flags.
//
// Ports
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   uart_rxd       serial input, idle high, asynchronous to clk_clk
//   rx_data        byte at the FIFO head (0 while the FIFO is empty)
//   rx_valid       FIFO not empty
//   rx_ready       consumer accepts rx_data when rx_valid & rx_ready
//   fifo_level     number of bytes currently stored (0..FIFO_DEPTH)
//   frame_err      sticky: stop bit sampled low
//   overrun_err    sticky: byte dropped because the FIFO was full
//   err_clear      single-cycle clear of both sticky flags
//
// Receiver states
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | line idle, waiting for rxs = 0
//   START     | validating the start bit at its centre
//   DATA      | collecting 8 data bits, LSB first
//   STOP      | sampling the stop bit; push on high, frame error on low
//   WAIT_HIGH | after a framing error, wait for the line to return high

module uart_rx_fifo #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             uart_rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             frame_err,
  output logic             overrun_err,
  input  logic             err_clear
);

  localparam int PRE_W = $clog2(BAUD_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(BAUD_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  // ---------------------------------------------------------------
  // Input synchronizer (resets to the idle-high line level)
  // ---------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------
  // Oversampling timebase
  // ---------------------------------------------------------------
  logic [2:0]       state;
  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       s_cnt;
  logic             tick;
  logic             start_det;
  logic             decide;
  logic             vote_7;
  logic             vote_8;
  logic             dec_bit;

  assign tick      = (pre_cnt == PRE_MAX);
  assign start_det = (state == IDLE) && !rxs;
  // the bit decision is taken on the s=9 tick, using the live rxs as
  // the third vote alongside the s=7 and s=8 samples
  assign decide    = tick && (s_cnt == 4'd9);
  assign dec_bit   = (vote_7 & vote_8) | (vote_7 & rxs) | (vote_8 & rxs);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre_cnt <= '0;
      s_cnt   <= 4'd0;
    end else if (start_det) begin
      // realign the timebase to the falling edge of the start bit
      pre_cnt <= '0;
      s_cnt   <= 4'd0;
    end else if (tick) begin
      pre_cnt <= '0;
      s_cnt   <= s_cnt + 4'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vote_7 <= 1'b1;
      vote_8 <= 1'b1;
    end else if (tick) begin
      if (s_cnt == 4'd7) vote_7 <= rxs;
      if (s_cnt == 4'd8) vote_8 <= rxs;
    end
  end

  // ---------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       push;
  logic       frame_set;

  assign push      = (state == STOP) && decide && dec_bit;
  assign frame_set = (state == STOP) && decide && !dec_bit;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) state <= START;
        end
        START: begin
          if (decide) begin
            if (dec_bit) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg <= {dec_bit, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (decide) begin
            if (dec_bit) state <= IDLE;
            else         state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovr_set;

  assign full    = (fifo_level == LVL_FULL);
  assign rx_valid = (fifo_level != '0);
  assign pop     = rx_valid && rx_ready;
  // a simultaneous pop frees the slot, so a push into a full FIFO only
  // drops when nothing is leaving in the same cycle
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign rx_data = rx_valid ? mem[rd_ptr] : 8'h00;

  // storage is not reset: emptiness is tracked by the level alone
  always_ff @(posedge clk_clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Sticky error flags (a set event outranks err_clear)
  // ---------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_set)      frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;

      if (ovr_set)        overrun_err <= 1'b1;
      else if (err_clear) overrun_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Fabric-side 8N1 UART receiver. It is the far end of the SoC UART's uart_external_txd line and lets FPGA logic consume bytes that the processor transmits. It oversamples the line 16x, decodes frames with majority voting and buffers bytes in a first-word-fall-through FIFO with a valid/ready output. Framing and overrun errors are sticky flags.

Parameters:
BAUD_DIV, 27, clk_clk cycles per 1/16 bit (50 MHz / (115200*16), rounded); legal range >= 2
FIFO_DEPTH, 16, FIFO entries; power of two, 2..256
LVL_W, 5, width of fifo_level; equals log2(FIFO_DEPTH)+1

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
uart_rxd  in  1  serial input, idle high, asynchronous to clk_clk
rx_data  out  8  byte at FIFO head
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
fifo_level  out  LVL_W  bytes currently stored
frame_err  out  1  sticky: stop bit sampled low
overrun_err  out  1  sticky: byte dropped because the FIFO was full
err_clear  in  1  single-cycle clear of both sticky flags

Behaviour:
- Reset values: rx_data=0, rx_valid=0, fifo_level=0, frame_err=0, overrun_err=0. The synchronizer flops reset to 1. FSM resets to IDLE. Prescaler and counters reset to 0. FIFO pointers reset to 0.
- uart_rxd passes through a 2-FF synchronizer. All decoding uses the synchronized value rxs.
- Prescaler counts 0..BAUD_DIV-1 and raises tick for one cycle when it reaches BAUD_DIV-1. It is forced to 0 on start detection.
- On each tick, sample counter s increments 0..15 and wraps. A bit decision takes the majority of rxs at s=7, 8 and 9 and is made on the s=9 tick.
- FSM:
  - IDLE: when rxs=0, clear prescaler and s, then go to START.
  - START: decision=1 is a false start and returns to IDLE. Decision=0 goes to DATA with bit index 0.
  - DATA: 8 decisions, one per 16 ticks, shifted in LSB first. After bit 7, go to STOP.
  - STOP: decision=1 pushes the byte into the FIFO. Decision=0 sets frame_err, discards the byte and goes to WAIT_HIGH.
  - After a good STOP, return to IDLE immediately. The next start edge may arrive from the s=10 point of the stop bit onward.
  - WAIT_HIGH: stay until rxs=1 (break or stuck-low line), then go to IDLE.
- Push latency: the byte is written on the stop-decision tick cycle. rx_valid and fifo_level reflect it on the next clock.
- FIFO is first-word-fall-through:
  - rx_data shows the head entry whenever rx_valid=1.
  - Pop happens when rx_valid & rx_ready. The next entry, if any, appears on the following clock.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level ranges 0..FIFO_DEPTH.
  - Push and pop in the same cycle: both take effect and fifo_level is unchanged. This also applies when full; the pop frees the slot, so no overrun.
  - Push when full without a pop: the byte is dropped, overrun_err sets, FIFO contents are unchanged.
  - rx_ready while empty has no effect.
- Sticky flags: err_clear clears both flags. If a set event and err_clear occur in the same cycle, the set wins.
- Reset asserted mid-frame: the partial byte is lost and FIFO contents are discarded. Reception restarts at the next falling edge after reset deasserts.

Test Plan:
1. Send 0x55, then 0xA3, at BAUD_DIV=27 with rx_ready=1 -> each appears with rx_valid=1 for exactly one cycle, data matches, fifo_level returns to 0, both error flags stay 0.
2. Send a 4-tick low glitch on idle line -> no push, FSM back in IDLE, fifo_level=0, frame_err=0.
3. Send 0x3C with stop bit driven low, line high 2 bit-times later -> frame_err=1, fifo_level=0. Then send 0x11 -> received correctly. err_clear pulse -> frame_err=0.
4. With rx_ready=0, send 17 bytes 0x00..0x10 -> fifo_level=16, overrun_err=1. Draining yields 0x00..0x0F in order, and 0x10 never appears.
5. Fill FIFO to 16, then pulse rx_ready exactly on the push cycle of byte 17 -> level stays 16, overrun_err=0, byte 17 appears last.
6. Assert reset_reset_n=0 during DATA bit 4 of a frame with 3 bytes queued -> all outputs at reset values. After release, a full 0xE7 frame is received as the only byte.
